// File: rtl/tl_uh_mem_responder.sv
// +----------------------------------------------------------------------------+
// | tl_uh_mem_responder: TileLink-UH slave backed by a word-addressed SRAM.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tl_uh_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_WORDS = 1024,
  parameter int          MAX_SIZE  = 6
) (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic [2:0]  tl_a_opcode,
  input  logic [2:0]  tl_a_param,
  input  logic [3:0]  tl_a_size,
  input  logic [31:0] tl_a_address,
  input  logic [3:0]  tl_a_mask,
  input  logic [31:0] tl_a_data,
  input  logic        tl_a_corrupt,
  input  logic        tl_a_valid,
  output logic        tl_a_ready,
  output logic [2:0]  tl_d_opcode,
  output logic [1:0]  tl_d_param,
  output logic [3:0]  tl_d_size,
  output logic        tl_d_denied,
  output logic [31:0] tl_d_data,
  output logic        tl_d_corrupt,
  output logic        tl_d_valid,
  input  logic        tl_d_ready
);

  localparam int          c_AW        = $clog2(MEM_WORDS);
  localparam logic [33:0] c_MEM_BYTES = 34'(MEM_WORDS) << 2;
  localparam logic [3:0]  c_MAX_SIZE  = 4'(MAX_SIZE);
  localparam logic [2:0]  c_OP_PUTFULL = 3'd0;
  localparam logic [2:0]  c_OP_PUTPART = 3'd1;
  localparam logic [2:0]  c_OP_GET     = 3'd4;
  localparam logic [2:0]  c_D_ACK      = 3'd0;
  localparam logic [2:0]  c_D_ACKDATA  = 3'd1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WACK, S_DRAIN, S_DENY} state_t;

  state_t            r_state;
  logic [13:0]       r_cnt;
  logic [13:0]       r_last;
  logic [c_AW-1:0]   r_idx;
  logic [31:0]       r_rd_data;
  logic              r_d_rdgood;
  logic              r_d_valid;
  logic [2:0]        r_d_opcode;
  logic [3:0]        r_d_size;
  logic              r_d_denied;
  logic              r_d_corrupt;
  logic [31:0]       r_mem [MEM_WORDS];

  logic              w_a_hs;
  logic              w_d_hs;
  logic [31:0]       w_off;
  logic [c_AW-1:0]   w_a_idx;
  logic [33:0]       w_bytes;
  logic [33:0]       w_end;
  logic              w_in_range;
  logic              w_aligned;
  logic              w_is_get;
  logic              w_is_put;
  logic              w_get_sized;
  logic              w_legal_get;
  logic              w_legal_put;
  logic [13:0]       w_beats_m1;
  logic              w_rd_last;
  logic              w_rd_en;
  logic [c_AW-1:0]   w_rd_idx;
  logic              w_wr_en;
  logic              w_unused;

  assign w_a_hs      = tl_a_valid & tl_a_ready;
  assign w_d_hs      = r_d_valid & tl_d_ready;
  assign w_off       = tl_a_address - BASE_ADDR;
  assign w_a_idx     = w_off[c_AW+1:2];
  assign w_bytes     = 34'd1 << tl_a_size;
  assign w_end       = {2'b00, w_off} + w_bytes;
  // Below-base addresses wrap w_off to a huge value, so both checks are needed.
  assign w_in_range  = (tl_a_address >= BASE_ADDR) && (w_end <= c_MEM_BYTES);
  assign w_aligned   = (tl_a_address & (w_bytes[31:0] - 32'd1)) == 32'd0;
  assign w_is_get    = (tl_a_opcode == c_OP_GET);
  assign w_is_put    = (tl_a_opcode == c_OP_PUTFULL) || (tl_a_opcode == c_OP_PUTPART);
  assign w_get_sized = w_is_get && (tl_a_size <= c_MAX_SIZE);
  assign w_legal_get = w_get_sized && w_aligned && w_in_range;
  assign w_legal_put = w_is_put && (tl_a_size <= 4'd2) && w_aligned && w_in_range;
  assign w_beats_m1  = (tl_a_size <= 4'd2) ? 14'd0
                                           : (14'd1 << (tl_a_size - 4'd2)) - 14'd1;
  assign w_rd_last   = (r_cnt == r_last);

  assign w_rd_en  = ((r_state == S_IDLE) && w_a_hs && w_is_get) ||
                    ((r_state == S_READ) && w_d_hs && !w_rd_last);
  assign w_rd_idx = (r_state == S_IDLE) ? w_a_idx : r_idx + c_AW'(1);
  assign w_wr_en  = (r_state == S_IDLE) && w_a_hs && w_legal_put &&
                    !tl_a_corrupt && !core_reset_i;

  assign w_unused = ^{tl_a_param, w_off[1:0], w_off[31:c_AW+2], w_end[33:32]};

  assign tl_a_ready   = !core_reset_i && ((r_state == S_IDLE) || (r_state == S_DRAIN));
  assign tl_d_valid   = r_d_valid;
  assign tl_d_opcode  = r_d_opcode;
  assign tl_d_param   = 2'b00;
  assign tl_d_size    = r_d_size;
  assign tl_d_denied  = r_d_denied;
  assign tl_d_corrupt = r_d_corrupt;
  assign tl_d_data    = r_d_rdgood ? r_rd_data : 32'h0;

  always_ff @(posedge core_clock_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_a_mask[b]) r_mem[w_a_idx][8*b +: 8] <= tl_a_data[8*b +: 8];
      end
    end
    if (w_rd_en) r_rd_data <= r_mem[w_rd_idx];
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= '0;
      r_idx       <= '0;
      r_d_rdgood  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_opcode  <= '0;
      r_d_size    <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_a_hs) begin
            r_d_size <= tl_a_size;
            r_cnt    <= '0;
            r_last   <= w_beats_m1;
            r_idx    <= w_a_idx;
            if (w_get_sized) begin
              r_state     <= S_READ;
              r_d_valid   <= 1'b1;
              r_d_opcode  <= c_D_ACKDATA;
              r_d_denied  <= !w_legal_get;
              r_d_corrupt <= !w_legal_get;
              r_d_rdgood  <= w_legal_get;
            end else if (w_legal_put) begin
              r_state     <= S_WACK;
              r_d_valid   <= 1'b1;
              r_d_opcode  <= c_D_ACK;
              r_d_denied  <= 1'b0;
              r_d_corrupt <= 1'b0;
              r_d_rdgood  <= 1'b0;
            end else if (w_is_put && (tl_a_size > 4'd2)) begin
              r_state     <= S_DRAIN;
            end else begin
              // Oversized Get gets a single denied data beat; everything else a plain ack.
              r_state     <= S_DENY;
              r_d_valid   <= 1'b1;
              r_d_opcode  <= w_is_get ? c_D_ACKDATA : c_D_ACK;
              r_d_denied  <= 1'b1;
              r_d_corrupt <= w_is_get;
              r_d_rdgood  <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (w_d_hs) begin
            if (w_rd_last) begin
              r_state   <= S_IDLE;
              r_d_valid <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 14'd1;
              r_idx <= w_rd_idx;
            end
          end
        end
        S_DRAIN: begin
          if (tl_a_valid) begin
            if (r_cnt == r_last - 14'd1) begin
              r_state     <= S_DENY;
              r_d_valid   <= 1'b1;
              r_d_opcode  <= c_D_ACK;
              r_d_denied  <= 1'b1;
              r_d_corrupt <= 1'b0;
              r_d_rdgood  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 14'd1;
            end
          end
        end
        S_WACK, S_DENY: begin
          if (w_d_hs) begin
            r_state   <= S_IDLE;
            r_d_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
